// File: rtl/sprite_mixer.sv
// rtl/sprite_mixer.sv - multi-channel sprite compositor, motion registers and VGA output stage
//
// Optional feature macro: SPRITE_MIXER_MOTION_EN (per-frame velocity motion with bounce/wrap).
// Without it, positions move only by register writes and frame is ignored.
//
// Ports:
//   clk_25MHz, btn_rst_n        pixel clock, synchronous active-low reset
//   frame                       one-cycle frame-start pulse, advances motion
//   bright, hsync_in, vsync_in  timing from vga_control
//   pix_in, drawing_in          per-channel pixel index and drawing flag
//   cfg_we, cfg_addr, cfg_wdata register write port (CLUT, position, velocity, control)
//   sprx_out, spry_out          per-channel position to the sprite instances
//   vga_hsync, vga_vsync        syncs delayed to match the 2-stage colour pipeline
//   vga_r, vga_g, vga_b         registered, blanked 8-bit colour

module sprite_mixer #(
    parameter int NSPR       = 4,
    parameter int CORDW      = 16,
    parameter int SPR_DATAW  = 4,
    parameter int TRANS_INDX = 'hF,
    parameter int BG_COLR    = 'h137,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int SPR_DRAWW  = 128,
    parameter int SPR_DRAWH  = 80
) (
    input  logic                      clk_25MHz,
    input  logic                      btn_rst_n,
    input  logic                      frame,
    input  logic                      bright,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic [NSPR*SPR_DATAW-1:0] pix_in,
    input  logic [NSPR-1:0]           drawing_in,
    input  logic                      cfg_we,
    input  logic [5:0]                cfg_addr,
    input  logic [15:0]               cfg_wdata,
    output logic [NSPR*CORDW-1:0]     sprx_out,
    output logic [NSPR*CORDW-1:0]     spry_out,
    output logic                      vga_hsync,
    output logic                      vga_vsync,
    output logic [7:0]                vga_r,
    output logic [7:0]                vga_g,
    output logic [7:0]                vga_b
);

    localparam logic [SPR_DATAW-1:0] TRANS = SPR_DATAW'(TRANS_INDX);
    localparam logic [11:0]          BG    = 12'(BG_COLR);

    logic [11:0]             clut  [16];
    logic signed [CORDW-1:0] pos_x [NSPR];
    logic signed [CORDW-1:0] pos_y [NSPR];
    logic [NSPR-1:0]         en;

    // Position writes are 16 bits wide; sign-extend or truncate to CORDW.
    logic signed [CORDW-1:0] wr_pos;
    assign wr_pos = CORDW'($signed(cfg_wdata));

`ifdef SPRITE_MIXER_MOTION_EN
    logic signed [7:0] vel_x [NSPR];
    logic signed [7:0] vel_y [NSPR];
    logic [NSPR-1:0]   bounce;

    localparam logic signed [CORDW:0] X_HI   = (CORDW+1)'(H_RES - SPR_DRAWW);
    localparam logic signed [CORDW:0] X_RES  = (CORDW+1)'(H_RES);
    localparam logic signed [CORDW:0] X_LO   = (CORDW+1)'(-SPR_DRAWW);
    localparam logic signed [CORDW:0] X_LAST = (CORDW+1)'(H_RES - 1);
    localparam logic signed [CORDW:0] Y_HI   = (CORDW+1)'(V_RES - SPR_DRAWH);
    localparam logic signed [CORDW:0] Y_RES  = (CORDW+1)'(V_RES);
    localparam logic signed [CORDW:0] Y_LO   = (CORDW+1)'(-SPR_DRAWH);
    localparam logic signed [CORDW:0] Y_LAST = (CORDW+1)'(V_RES - 1);

    // One axis of motion; returns {new velocity, new position}. The sum is
    // formed one bit wider than CORDW so edge positions cannot overflow.
    function automatic logic [CORDW+7:0] axis_step(
        input logic signed [CORDW-1:0] p,
        input logic signed [7:0]       v,
        input logic                    b,
        input logic signed [CORDW:0]   hi,
        input logic signed [CORDW:0]   res,
        input logic signed [CORDW:0]   lo,
        input logic signed [CORDW:0]   last
    );
        logic signed [CORDW:0]   n;
        logic signed [CORDW-1:0] np;
        logic signed [7:0]       nv;
        n  = (CORDW+1)'(p) + (CORDW+1)'(v);
        np = n[CORDW-1:0];
        nv = v;
        if (b) begin
            if (n > hi) begin
                np = hi[CORDW-1:0];
                nv = -v;
            end else if (n[CORDW]) begin
                np = '0;
                nv = -v;
            end
        end else begin
            if (n >= res)
                np = lo[CORDW-1:0];
            else if (n < lo)
                np = last[CORDW-1:0];
        end
        return {nv, np};
    endfunction
`else
    logic unused_motion;
    assign unused_motion = ^{frame, 32'(H_RES), 32'(V_RES), 32'(SPR_DRAWW), 32'(SPR_DRAWH)};
`endif

    // Register file and motion. Writes are issued after motion so that a
    // write coincident with frame overrides the moved value of that register.
    always_ff @(posedge clk_25MHz) begin
        if (!btn_rst_n) begin
            for (int n = 0; n < 16; n++)
                clut[n] <= {4'(n), 4'(n), 4'(n)};
            for (int c = 0; c < NSPR; c++) begin
                pos_x[c] <= '0;
                pos_y[c] <= '0;
`ifdef SPRITE_MIXER_MOTION_EN
                vel_x[c] <= '0;
                vel_y[c] <= '0;
`endif
            end
            en <= '0;
`ifdef SPRITE_MIXER_MOTION_EN
            bounce <= '0;
`endif
        end else begin
`ifdef SPRITE_MIXER_MOTION_EN
            if (frame) begin
                for (int c = 0; c < NSPR; c++) begin
                    if (en[c]) begin
                        {vel_x[c], pos_x[c]} <= axis_step(pos_x[c], vel_x[c], bounce[c],
                                                          X_HI, X_RES, X_LO, X_LAST);
                        {vel_y[c], pos_y[c]} <= axis_step(pos_y[c], vel_y[c], bounce[c],
                                                          Y_HI, Y_RES, Y_LO, Y_LAST);
                    end
                end
            end
`endif
            if (cfg_we) begin
                if (cfg_addr[5:4] == 2'b00) begin
                    clut[cfg_addr[3:0]] <= cfg_wdata[11:0];
                end else if (cfg_addr[5]) begin
                    for (int c = 0; c < NSPR; c++) begin
                        if (cfg_addr[4:2] == 3'(c)) begin
                            case (cfg_addr[1:0])
                                2'd0: pos_x[c] <= wr_pos;
                                2'd1: pos_y[c] <= wr_pos;
                                2'd2: begin
`ifdef SPRITE_MIXER_MOTION_EN
                                    vel_x[c] <= cfg_wdata[7:0];
                                    vel_y[c] <= cfg_wdata[15:8];
`endif
                                end
                                default: begin
                                    en[c] <= cfg_wdata[0];
`ifdef SPRITE_MIXER_MOTION_EN
                                    bounce[c] <= cfg_wdata[1];
`endif
                                end
                            endcase
                        end
                    end
                end
            end
        end
    end

    // Priority mix: scanning from the highest channel down lets the lowest
    // qualifying channel overwrite the result last.
    logic [3:0] mix_idx;
    logic       mix_hit;

    always_comb begin
        mix_idx = '0;
        mix_hit = 1'b0;
        for (int c = NSPR - 1; c >= 0; c--) begin
            if (en[c] && drawing_in[c] && pix_in[c*SPR_DATAW +: SPR_DATAW] != TRANS) begin
                mix_idx = 4'(pix_in[c*SPR_DATAW +: SPR_DATAW]);
                mix_hit = 1'b1;
            end
        end
    end

    logic [3:0]  idx_s1;
    logic        hit_s1;
    logic        bright_s1;
    logic        hsync_s1;
    logic        vsync_s1;
    logic [11:0] colr_s2;

    assign colr_s2 = hit_s1 ? clut[idx_s1] : BG;

    always_ff @(posedge clk_25MHz) begin
        if (!btn_rst_n) begin
            idx_s1    <= '0;
            hit_s1    <= 1'b0;
            bright_s1 <= 1'b0;
            hsync_s1  <= 1'b1;
            vsync_s1  <= 1'b1;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            idx_s1    <= mix_idx;
            hit_s1    <= mix_hit;
            bright_s1 <= bright;
            hsync_s1  <= hsync_in;
            vsync_s1  <= vsync_in;
            vga_r     <= bright_s1 ? {colr_s2[11:8], 4'h0} : 8'h00;
            vga_g     <= bright_s1 ? {colr_s2[7:4],  4'h0} : 8'h00;
            vga_b     <= bright_s1 ? {colr_s2[3:0],  4'h0} : 8'h00;
            vga_hsync <= hsync_s1;
            vga_vsync <= vsync_s1;
        end
    end

    for (genvar g = 0; g < NSPR; g++) begin : g_pos_out
        assign sprx_out[g*CORDW +: CORDW] = pos_x[g];
        assign spry_out[g*CORDW +: CORDW] = pos_y[g];
    end

endmodule

// File: tb/tb_sprite_mixer.sv
// tb/tb_sprite_mixer.sv - self-checking bench for sprite_mixer

module tb_sprite_mixer;

    logic        clk_25MHz;
    logic        btn_rst_n;
    logic        frame;
    logic        bright;
    logic        hsync_in;
    logic        vsync_in;
    logic [15:0] pix_in;
    logic [3:0]  drawing_in;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [63:0] sprx_out;
    logic [63:0] spry_out;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    int checks = 0;
    int errors = 0;

    sprite_mixer dut (
        .clk_25MHz (clk_25MHz),
        .btn_rst_n (btn_rst_n),
        .frame     (frame),
        .bright    (bright),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .pix_in    (pix_in),
        .drawing_in(drawing_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .sprx_out  (sprx_out),
        .spry_out  (spry_out),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b)
    );

    initial clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    typedef struct {
        logic [3:0]  drawing;
        logic [15:0] pix;
        logic        bright;
        logic        hs;
        logic        vs;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [15:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic check_rgb(input string name, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b);
        check({name, "_r"}, 32'(vga_r), 32'(r));
        check({name, "_g"}, 32'(vga_g), 32'(g));
        check({name, "_b"}, 32'(vga_b), 32'(b));
    endtask

    function automatic logic [15:0] gx(input int c);
        return sprx_out[c*16 +: 16];
    endfunction

    function automatic logic [15:0] gy(input int c);
        return spry_out[c*16 +: 16];
    endfunction

    initial begin
        // Channels 0..2 enabled for the mix table, channel 3 left disabled.
        // pix is {ch3, ch2, ch1, ch0}; CLUT is the default grey ramp.
        vecs[0] = '{4'b0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 8'h10, 8'h30, 8'h70};
        vecs[1] = '{4'b0101, 16'h0503, 1'b1, 1'b0, 1'b1, 8'h30, 8'h30, 8'h30};
        vecs[2] = '{4'b0101, 16'h050F, 1'b1, 1'b1, 1'b0, 8'h50, 8'h50, 8'h50};
        vecs[3] = '{4'b1000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 8'h10, 8'h30, 8'h70};
        vecs[4] = '{4'b0110, 16'h0900, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{4'b0100, 16'h0A00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{4'b0100, 16'h0C02, 1'b1, 1'b1, 1'b0, 8'hC0, 8'hC0, 8'hC0};
        vecs[7] = '{4'b0111, 16'h0E48, 1'b1, 1'b1, 1'b1, 8'h80, 8'h80, 8'h80};
        vecs[8] = '{4'b0011, 16'h00FF, 1'b1, 1'b0, 1'b1, 8'h10, 8'h30, 8'h70};

        btn_rst_n  = 1'b0;
        frame      = 1'b0;
        bright     = 1'b0;
        hsync_in   = 1'b0;
        vsync_in   = 1'b0;
        pix_in     = 16'hFFFF;
        drawing_in = 4'b0000;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        tick();
        tick();

        check_rgb("reset_rgb", 8'h00, 8'h00, 8'h00);
        check("reset_hsync", 32'(vga_hsync), 32'h1);
        check("reset_vsync", 32'(vga_vsync), 32'h1);
        check("reset_x0", 32'(gx(0)), 32'h0);
        check("reset_y3", 32'(gy(3)), 32'h0);

        btn_rst_n = 1'b1;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        cfg_write(6'h23, 16'h0001);
        cfg_write(6'h27, 16'h0001);
        cfg_write(6'h2B, 16'h0001);

        // Streamed vectors: output after tick j belongs to the vector driven at j-1.
        for (int j = 0; j <= NVEC; j++) begin
            if (j < NVEC) begin
                drawing_in = vecs[j].drawing;
                pix_in     = vecs[j].pix;
                bright     = vecs[j].bright;
                hsync_in   = vecs[j].hs;
                vsync_in   = vecs[j].vs;
            end
            tick();
            if (j >= 1) begin
                check_rgb($sformatf("vec%0d", j - 1), vecs[j-1].r, vecs[j-1].g, vecs[j-1].b);
                check($sformatf("vec%0d_hs", j - 1), 32'(vga_hsync), 32'(vecs[j-1].hs));
                check($sformatf("vec%0d_vs", j - 1), 32'(vga_vsync), 32'(vecs[j-1].vs));
            end
        end
        hsync_in = 1'b1;
        vsync_in = 1'b1;

        // CLUT rewrite and blanking.
        cfg_write(6'h05, 16'h0F80);
        drawing_in = 4'b0001;
        pix_in     = 16'h0005;
        bright     = 1'b1;
        tick();
        tick();
        check_rgb("clut5", 8'hF0, 8'h80, 8'h00);
        bright = 1'b0;
        tick();
        tick();
        check_rgb("blank", 8'h00, 8'h00, 8'h00);

        // Address 0x10 is unmapped and must not alias onto CLUT[0].
        cfg_write(6'h10, 16'h0FFF);
        pix_in = 16'h0000;
        bright = 1'b1;
        tick();
        tick();
        check_rgb("unmapped", 8'h00, 8'h00, 8'h00);

        // Position registers and out-of-range channel writes.
        cfg_write(6'h24, 16'hFFF0);
        check("wr_x1", 32'(gx(1)), 32'hFFF0);
        cfg_write(6'h2D, 16'd100);
        check("wr_y3", 32'(gy(3)), 32'd100);
        cfg_write(6'h34, 16'h1234);
        check("ch5_x1", 32'(gx(1)), 32'hFFF0);
        check("ch5_x0", 32'(gx(0)), 32'h0);

`ifdef SPRITE_MIXER_MOTION_EN
        // Bounce on ch1: 500 -> 504 -> 508 -> 512 (not beyond 512, vx stays +4),
        // then 516 > 512 clamps to 512 with vx=-4, then 508.
        cfg_write(6'h24, 16'd500);
        cfg_write(6'h26, 16'h0004);
        cfg_write(6'h27, 16'h0003);
        pulse_frame();
        check("bnc_f1", 32'(gx(1)), 32'd504);
        pulse_frame();
        pulse_frame();
        check("bnc_f3", 32'(gx(1)), 32'd512);
        pulse_frame();
        check("bnc_f4", 32'(gx(1)), 32'd512);
        pulse_frame();
        check("bnc_f5", 32'(gx(1)), 32'd508);
        check("bnc_y1", 32'(gy(1)), 32'h0);

        // Wrap on ch0 on both axes: X 638+4 -> -128, Y 478+4 -> -80.
        cfg_write(6'h20, 16'd638);
        cfg_write(6'h21, 16'd478);
        cfg_write(6'h22, 16'h0404);
        pulse_frame();
        check("wrap_x0", 32'(gx(0)), 32'hFF80);
        check("wrap_y0", 32'(gy(0)), 32'hFFB0);

        // Write coincident with frame wins for X; Y still moves.
        cfg_we    = 1'b1;
        cfg_addr  = 6'h20;
        cfg_wdata = 16'd10;
        frame     = 1'b1;
        tick();
        cfg_we = 1'b0;
        frame  = 1'b0;
        check("coin_x0", 32'(gx(0)), 32'd10);
        check("coin_y0", 32'(gy(0)), 32'hFFB4);
        pulse_frame();
        check("after_x0", 32'(gx(0)), 32'd14);

        // Low-side wrap on ch2: -128 - 4 < -128 -> 639.
        cfg_write(6'h28, 16'hFF80);
        cfg_write(6'h2A, 16'h00FC);
        pulse_frame();
        check("wrap_lo_x2", 32'(gx(2)), 32'd639);
`else
        // Without motion, frame and velocity have no effect on positions.
        cfg_write(6'h20, 16'd100);
        cfg_write(6'h22, 16'h0404);
        cfg_write(6'h23, 16'h0003);
        pulse_frame();
        check("nomot_x0", 32'(gx(0)), 32'd100);
        check("nomot_y0", 32'(gy(0)), 32'h0);
        cfg_we    = 1'b1;
        cfg_addr  = 6'h20;
        cfg_wdata = 16'd10;
        frame     = 1'b1;
        tick();
        cfg_we = 1'b0;
        frame  = 1'b0;
        check("nomot_coin_x0", 32'(gx(0)), 32'd10);
        pulse_frame();
        check("nomot_hold_x0", 32'(gx(0)), 32'd10);
`endif

        // Reset during active video coincident with frame.
        cfg_write(6'h23, 16'h0001);
        drawing_in = 4'b0001;
        pix_in     = 16'h0003;
        bright     = 1'b1;
        hsync_in   = 1'b0;
        vsync_in   = 1'b0;
        tick();
        tick();
        check_rgb("pre_rst", 8'h30, 8'h30, 8'h30);
        btn_rst_n = 1'b0;
        frame     = 1'b1;
        tick();
        frame = 1'b0;
        check_rgb("mid_rst", 8'h00, 8'h00, 8'h00);
        check("mid_rst_hs", 32'(vga_hsync), 32'h1);
        check("mid_rst_vs", 32'(vga_vsync), 32'h1);
        check("mid_rst_x0", 32'(gx(0)), 32'h0);
        check("mid_rst_x1", 32'(gx(1)), 32'h0);
        check("mid_rst_y0", 32'(gy(0)), 32'h0);
        check("mid_rst_y3", 32'(gy(3)), 32'h0);
        btn_rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
